// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the adder tree: level count and per-level
// operand count / width.
package adder_tree_pkg;

  function automatic int tree_levels(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int half_up(input int n);
    return (n + 1) / 2;
  endfunction

  // Operands entering level lvl: each earlier level halves the count, rounding up.
  function automatic int level_nb(input int nb, input int lvl);
    int n;
    n = nb;
    for (int i = 0; i < lvl; i++) n = half_up(n);
    return n;
  endfunction

  function automatic int level_width(input int w, input int lvl);
    return w + lvl;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One reduction level: adds adjacent pairs (2k, 2k+1) one bit wider, passes an
// odd last operand through, and optionally registers the result with its valid.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int NB  = 2,
  parameter int W   = 32,
  parameter int REG = 0
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic [W-1:0] data_i [NB-1:0],
  input  logic         valid_i,
  output logic [W:0]   data_o [half_up(NB)-1:0],
  output logic         valid_o
);

  localparam int NO = half_up(NB);

  logic [W:0] sum_s [NO-1:0];

  for (genvar k = 0; k < NO; k++) begin : g_pair
    if (2 * k + 1 < NB) begin : g_add
      assign sum_s[k] = {1'b0, data_i[2*k]} + {1'b0, data_i[2*k+1]};
    end else begin : g_pass
      assign sum_s[k] = {1'b0, data_i[2*k]};
    end
  end

  if (REG != 0) begin : g_reg
    logic [W:0] data_q [NO-1:0];
    logic       valid_q;

    // Stage register: data only loads on a valid slot so the last result is held.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        valid_q <= 1'b0;
        for (int k = 0; k < NO; k++) data_q[k] <= '0;
      end else begin
        valid_q <= valid_i;
        if (valid_i) data_q <= sum_s;
      end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
  end else begin : g_comb
    logic unused_s;
    assign unused_s = clk ^ aresetn;
    assign data_o   = sum_s;
    assign valid_o  = valid_i;
  end

endmodule

// File: rtl/adder_tree.sv
// Pipelined or single-register unsigned adder tree over NB_IN operands.
// The tree is a generate chain of adder_tree_level instances.
module adder_tree
  import adder_tree_pkg::*;
#(
  parameter int NB_IN     = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = NB_IN + IN_WIDTH,
  parameter int USE_PIPE  = 0
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [IN_WIDTH-1:0]  data_in [NB_IN-1:0],
  input  logic                 data_in_en,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_out_en
);

  localparam int L     = tree_levels(NB_IN);
  localparam int SUM_W = level_width(IN_WIDTH, L);
  localparam bit PIPE_OUT = (USE_PIPE != 0) && (L > 0);

  logic [SUM_W-1:0] sum_s;
  logic             sum_vld_s;

  if (L == 0) begin : g_single
    assign sum_s     = data_in[0];
    assign sum_vld_s = data_in_en;
  end else begin : g_tree
    for (genvar lv = 0; lv < L; lv++) begin : g_lvl
      localparam int NI = level_nb(NB_IN, lv);
      localparam int NO = level_nb(NB_IN, lv + 1);
      localparam int WI = level_width(IN_WIDTH, lv);

      logic [WI-1:0] din_s  [NI-1:0];
      logic [WI:0]   dout_s [NO-1:0];
      logic          vin_s;
      logic          vout_s;

      if (lv == 0) begin : g_src
        assign din_s = data_in;
        assign vin_s = data_in_en;
      end else begin : g_src
        assign din_s = g_lvl[lv-1].dout_s;
        assign vin_s = g_lvl[lv-1].vout_s;
      end

      adder_tree_level #(
        .NB  (NI),
        .W   (WI),
        .REG (USE_PIPE)
      ) u_level (
        .clk     (clk),
        .aresetn (aresetn),
        .data_i  (din_s),
        .valid_i (vin_s),
        .data_o  (dout_s),
        .valid_o (vout_s)
      );
    end

    assign sum_s     = g_lvl[L-1].dout_s[0];
    assign sum_vld_s = g_lvl[L-1].vout_s;
  end

  // With a registered tree the last level register already is the output register.
  if (PIPE_OUT) begin : g_out_pipe
    assign data_out    = OUT_WIDTH'(sum_s);
    assign data_out_en = sum_vld_s;
  end else begin : g_out_reg
    logic [OUT_WIDTH-1:0] data_d;
    logic [OUT_WIDTH-1:0] data_q;
    logic                 en_d;
    logic                 en_q;

    // Next-state: capture a fresh sum only on a valid slot, otherwise hold.
    always_comb begin
      data_d = data_q;
      en_d   = sum_vld_s;
      if (sum_vld_s) begin
        data_d = OUT_WIDTH'(sum_s);
      end else begin
        data_d = data_q;
      end
    end

    // Output register.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        data_q <= '0;
        en_q   <= 1'b0;
      end else begin
        data_q <= data_d;
        en_q   <= en_d;
      end
    end

    assign data_out    = data_q;
    assign data_out_en = en_q;
  end

endmodule

// File: tb/tb_adder_tree.sv
// Self-checking bench: four adder_tree configurations (4/5 operands, with and
// without pipelining) driven together and compared with a slot-history model.
module tb_adder_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic        en;
  logic [31:0] d4 [3:0];
  logic [31:0] d5 [4:0];
  logic [35:0] o0, o1;
  logic [36:0] o2, o3;
  logic        e0, e1, e2, e3;

  adder_tree #(.NB_IN(4), .USE_PIPE(0)) u0 (.clk(clk), .aresetn(aresetn), .data_in(d4),
    .data_in_en(en), .data_out(o0), .data_out_en(e0));
  adder_tree #(.NB_IN(4), .USE_PIPE(1)) u1 (.clk(clk), .aresetn(aresetn), .data_in(d4),
    .data_in_en(en), .data_out(o1), .data_out_en(e1));
  adder_tree #(.NB_IN(5), .USE_PIPE(0)) u2 (.clk(clk), .aresetn(aresetn), .data_in(d5),
    .data_in_en(en), .data_out(o2), .data_out_en(e2));
  adder_tree #(.NB_IN(5), .USE_PIPE(1)) u3 (.clk(clk), .aresetn(aresetn), .data_in(d5),
    .data_in_en(en), .data_out(o3), .data_out_en(e3));

  logic [63:0] od [4];
  logic        oe [4];
  assign od[0] = 64'(o0);
  assign od[1] = 64'(o1);
  assign od[2] = 64'(o2);
  assign od[3] = 64'(o3);
  assign oe[0] = e0;
  assign oe[1] = e1;
  assign oe[2] = e2;
  assign oe[3] = e3;

  // Latency in clock edges: 1 for single register, ceil(log2(N)) when pipelined.
  localparam int LAT  [4] = '{1, 2, 1, 3};
  localparam bit FIVE [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  int vectors = 0;
  int errors  = 0;
  int cur     = -1;
  int base    = 0;
  bit          en_h [$];
  logic [63:0] s4_h [$];
  logic [63:0] s5_h [$];

  // Model: record what each rising edge accepted, as plain arithmetic sums.
  task automatic tick();
    logic [63:0] a, b;
    a = 64'd0;
    b = 64'd0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) a += 64'(d4[i]);
    for (int i = 0; i < 5; i++) b += 64'(d5[i]);
    cur++;
    en_h.push_back(en && aresetn);
    s4_h.push_back(a);
    s5_h.push_back(b);
    @(negedge clk);
  endtask

  function automatic bit exp_en(input int lat);
    int m;
    m = cur - lat + 1;
    if (m >= base && m >= 0) return en_h[m];
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_data(input int lat, input bit five);
    for (int i = cur - lat + 1; i >= base && i >= 0; i--)
      if (en_h[i]) return five ? s5_h[i] : s4_h[i];
    return 64'd0;
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < 4; i++) d4[i] = $urandom;
    for (int i = 0; i < 5; i++) d5[i] = $urandom;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    en = 1'b0;
    rand_inputs();
    tick();
    tick();
    for (int u = 0; u < 4; u++) begin
      vectors++;
      if (oe[u] !== 1'b0 || od[u] !== 64'd0) begin
        errors++;
        $display("FAIL reset u%0d: got en=%0b data=%0h want en=0 data=0", u, oe[u], od[u]);
      end
    end
    aresetn = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) d4[i] = 32'(i + 1);
    for (int i = 0; i < 5; i++) d5[i] = 32'(i + 1);
    en = 1'b1;
    tick();
    en = 1'b0;
    rand_inputs();
    for (int t = 1; t <= 4; t++) begin
      for (int u = 0; u < 4; u++) begin
        vectors++;
        if (oe[u] !== exp_en(LAT[u]) || od[u] !== exp_data(LAT[u], FIVE[u])) begin
          errors++;
          $display("FAIL basic u%0d t%0d: got en=%0b data=%0h want en=%0b data=%0h",
                   u, t, oe[u], od[u], exp_en(LAT[u]), exp_data(LAT[u], FIVE[u]));
        end
        if (t == LAT[u]) begin
          vectors++;
          if (oe[u] !== 1'b1 || od[u] !== (FIVE[u] ? 64'd15 : 64'd10)) begin
            errors++;
            $display("FAIL basic_const u%0d: got en=%0b data=%0d want en=1 data=%0d",
                     u, oe[u], od[u], FIVE[u] ? 15 : 10);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 4; i++) d4[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) d5[i] = 32'hFFFF_FFFF;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      for (int u = 0; u < 4; u++) begin
        if (t == LAT[u]) begin
          vectors++;
          if (oe[u] !== 1'b1 || od[u] !== (FIVE[u] ? 64'h4_FFFF_FFFB : 64'h3_FFFF_FFFC)) begin
            errors++;
            $display("FAIL max u%0d: got en=%0b data=%0h want en=1 data=%0h",
                     u, oe[u], od[u], FIVE[u] ? 64'h4_FFFF_FFFB : 64'h3_FFFF_FFFC);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int vals [12] = '{1, 1, 1, 1, 5, 6, 7, 8, 0, 0, 0, 0};
    int want [3]  = '{4, 26, 0};
    for (int t = 0; t < 6; t++) begin
      if (t < 3) begin
        for (int i = 0; i < 4; i++) d4[i] = 32'(vals[t*4+i]);
        for (int i = 0; i < 5; i++) d5[i] = $urandom;
        en = 1'b1;
      end else begin
        en = 1'b0;
        rand_inputs();
      end
      tick();
      for (int u = 0; u < 4; u++) begin
        vectors++;
        if (oe[u] !== exp_en(LAT[u]) || od[u] !== exp_data(LAT[u], FIVE[u])) begin
          errors++;
          $display("FAIL b2b u%0d t%0d: got en=%0b data=%0h want en=%0b data=%0h",
                   u, t, oe[u], od[u], exp_en(LAT[u]), exp_data(LAT[u], FIVE[u]));
        end
      end
      if (t >= 1 && t <= 3) begin
        vectors++;
        if (e1 !== 1'b1 || od[1] !== 64'(want[t-1])) begin
          errors++;
          $display("FAIL b2b_pipe t%0d: got en=%0b data=%0d want en=1 data=%0d",
                   t, e1, od[1], want[t-1]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    rand_inputs();
    en = 1'b1;
    tick();
    en = 1'b0;
    aresetn = 1'b0;
    base = cur + 1;
    #1;
    for (int u = 0; u < 4; u++) begin
      vectors++;
      if (oe[u] !== 1'b0 || od[u] !== 64'd0) begin
        errors++;
        $display("FAIL rst_async u%0d: got en=%0b data=%0h want en=0 data=0", u, oe[u], od[u]);
      end
    end
    tick();
    aresetn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      for (int u = 0; u < 4; u++) begin
        vectors++;
        if (oe[u] !== 1'b0 || od[u] !== 64'd0) begin
          errors++;
          $display("FAIL rst_inflight u%0d t%0d: got en=%0b data=%0h want en=0 data=0",
                   u, t, oe[u], od[u]);
        end
      end
    end
  endtask

  task automatic test_idle();
    rand_inputs();
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 0; t < 8; t++) begin
      rand_inputs();
      tick();
      for (int u = 0; u < 4; u++) begin
        vectors++;
        if (oe[u] !== exp_en(LAT[u]) || od[u] !== exp_data(LAT[u], FIVE[u])) begin
          errors++;
          $display("FAIL idle u%0d t%0d: got en=%0b data=%0h want en=%0b data=%0h",
                   u, t, oe[u], od[u], exp_en(LAT[u]), exp_data(LAT[u], FIVE[u]));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 200; t++) begin
      rand_inputs();
      if ($urandom_range(0, 7) == 0) d4[$urandom_range(0, 3)] = 32'hFFFF_FFFF;
      en = ($urandom_range(0, 2) != 0);
      tick();
      for (int u = 0; u < 4; u++) begin
        vectors++;
        if (oe[u] !== exp_en(LAT[u]) || od[u] !== exp_data(LAT[u], FIVE[u])) begin
          errors++;
          $display("FAIL random u%0d t%0d: got en=%0b data=%0h want en=%0b data=%0h",
                   u, t, oe[u], od[u], exp_en(LAT[u]), exp_data(LAT[u], FIVE[u]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_reset_inflight();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree.md
ADDER_TREE -- requirements
Module: adder_tree

Interface
REQ-001 SHALL have parameter NB_IN, default 4: number of input operands, >=1.
REQ-002 SHALL have parameter IN_WIDTH, default 32: width of each operand, unsigned.
REQ-003 SHALL have parameter OUT_WIDTH, default NB_IN+IN_WIDTH: result width.
REQ-004 SHALL have parameter USE_PIPE, default 0: 0 = single output register, 1 = register after every tree level.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port data_in  input  unpacked array [NB_IN-1:0] of [IN_WIDTH-1:0]  operands.
REQ-008 SHALL have port data_in_en  input  1  operands valid this cycle.
REQ-009 SHALL have port data_out  output  OUT_WIDTH  registered sum.
REQ-010 SHALL have port data_out_en  output  1  one-cycle pulse, data_out valid.

Function
REQ-011 SHALL compute data_out = unsigned sum of data_in[0..NB_IN-1], zero-extended, modulo 2^OUT_WIDTH.
REQ-012 SHALL use L = ceil(log2(NB_IN)) pairwise levels; each level adds adjacent pairs (2k, 2k+1).
REQ-013 SHALL pass an unpaired (odd last) element unchanged to the next level.
REQ-014 SHALL widen intermediate sums by 1 bit per level so no overflow occurs when OUT_WIDTH >= IN_WIDTH+L.
REQ-015 SHALL, when OUT_WIDTH < IN_WIDTH+L, truncate to the OUT_WIDTH LSBs.
REQ-016 SHALL, with USE_PIPE=0, register the combinational sum: data_out/data_out_en valid exactly 1 cycle after the edge sampling data_in_en=1.
REQ-017 SHALL, with USE_PIPE=1, register every level: latency max(L,1) cycles (NB_IN=4: 2 cycles).
REQ-018 SHALL carry a valid bit alongside each pipeline stage; data_out_en = valid of last stage.
REQ-019 SHALL accept a new operand set every cycle (no backpressure); results emerge in input order, one per accepted set.
REQ-020 SHALL ignore data_in while data_in_en=0; data_out_en stays 0 for that slot.
REQ-021 SHALL hold data_out at the last valid result while data_out_en=0.

Reset
REQ-022 SHALL, on aresetn=0, immediately clear data_out to 0, data_out_en to 0 and all pipeline data/valid registers to 0.
REQ-023 SHALL discard any in-flight sums on reset; no data_out_en pulse for sets accepted before reset.
REQ-024 SHALL accept data_in_en on the first rising edge after aresetn deasserts.

Structure
REQ-025 SHALL place level-count/width helper (ceil-log2, per-level width) in shared package adder_tree_pkg.
REQ-026 SHALL implement one level as sub-module adder_tree_level (pairwise add, odd pass-through, optional register), instantiated L times via generate.
REQ-027 SHALL handle NB_IN=1 as pass-through with one output register.

Verification
REQ-028 SHALL verify USE_PIPE=0, data_in={1,2,3,4}, en pulse -> data_out=10, data_out_en high for exactly 1 cycle, 1 cycle later.
REQ-029 SHALL verify all operands 0xFFFFFFFF -> data_out=0x3FFFFFFFC (no overflow in 36 bits).
REQ-030 SHALL verify USE_PIPE=1, back-to-back sets {1,1,1,1},{5,6,7,8},{0,0,0,0} -> 4,26,0 on consecutive cycles, 2-cycle latency.
REQ-031 SHALL verify NB_IN=5, {1,2,3,4,5} -> 15 (odd pass-through), both USE_PIPE values.
REQ-032 SHALL verify aresetn asserted one cycle after en in USE_PIPE=1 -> data_out=0, no data_out_en pulse.
REQ-033 SHALL verify idle inputs changing with en=0 -> data_out holds prior value, data_out_en stays 0.
